seq_sorter_n: RTL and testbench
===============================

# seq_sorter_n

Parametrised frame sorter for streams of DW-bit unsigned samples. It accepts a frame of 1..N samples over a valid/ready input, keeps them in an insertion-sorted register chain of N compare-and-shift cells, and then drains the frame in ascending or descending order over a valid/ready output. It is the generalised successor of the fixed four-deep comparator-chain sorter. It adds:
- configurable depth,
- sort direction,
- variable frame length,
- backpressure on both sides.

## Interface
- DW, 8, sample width in bits (unsigned compare)
- N, 4, maximum frame length = number of sort cells (N >= 2)
- CW, $clog2(N+1), occupancy counter width (derived, not overridden)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  DW  input sample
- in_last  in  1  marks last sample of a frame (ends frame early)
- descend  in  1  0 = ascending output, 1 = descending; sampled with first sample of frame
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output this cycle
- out_data  out  DW  sorted sample
- out_last  out  1  marks last output sample of the frame

## Operation
- State machine LOAD / DRAIN; reset state LOAD.
- Cells c[0..N-1], each DW bits; occupancy k (CW bits); latched direction dir.
- LOAD:
  - in_ready = 1 (0 while rst high).
  - On accept with x = in_data: prec(a,b) = dir ? (a > b) : (a < b), strict.
  - ins[i] = (i >= k) | prec(x, c[i]); ins[-1] = 0.
  - c[i] <= ins[i] ? (ins[i-1] ? c[i-1] : x) : c[i].
  - k <= k+1.
  - Equal values keep arrival order (stable).
- Direction latch: on accept with k == 0, the incoming sample is compared using descend directly and dir <= descend. descend is ignored for the rest of the frame.
- Frame end: accept with in_last = 1, or accept that makes k == N. Next state is DRAIN.
- DRAIN:
  - in_ready = 0; out_valid = 1; out_data = c[0]; out_last = (k == 1).
  - On out_ready: c[i] <= c[i+1], c[N-1] <= 0, k <= k-1.
  - On the out_last handshake: k becomes 0 and next state is LOAD.
- Outside DRAIN: out_valid = 0, out_last = 0, out_data = c[0] (don't-care, 0 after reset).
- rst (any state, including mid-load or mid-drain): state = LOAD, k = 0, all c = 0, dir = 0. The partial frame is discarded and no output is produced for it.
- in_data / in_last are ignored when in_valid = 0 or in_ready = 0.

## Timing
- Reset values: in_ready 0 during rst and 1 in the first cycle after rst drops. out_valid 0, out_data 0, out_last 0.
- Insertion is single-cycle; the N compares run in parallel (combinational depth: one DW compare plus one mux level).
- Latency: first sorted sample is valid on the cycle after the frame-ending input handshake.
- Throughput with no stalls: a frame of L samples takes L load cycles plus L drain cycles. There is no overlap between frames.
- out_data / out_valid / out_last are held stable while out_valid = 1 and out_ready = 0.
- Input is never accepted during DRAIN, including the cycle of the out_last handshake. LOAD resumes on the following cycle.
- in_last on the Nth sample is the same as a natural frame end (no extra cycle).

## Test plan
- Ascending, N=4, DW=8, descend=0:
  - Stimulus: 9, 3, 7, 1 back-to-back, in_last on 1, out_ready=1.
  - Required: out_valid from the cycle after the 4th accept, out_data 1, 3, 7, 9 on consecutive cycles, out_last only with 9, in_ready back to 1 the cycle after.
- Descending and latch:
  - Stimulus: descend=1 on the first sample and toggled to 0 mid-frame; 5, 200, 5, 0.
  - Required: output 200, 5, 5, 0, with the direction unaffected by the toggle.
- Short frame and auto-close:
  - Stimulus (a): 42, 17 with in_last on 17. Required: output 17, 42, out_last on 42.
  - Stimulus (b): 4 samples with no in_last. Required: drain starts after the 4th sample.
- Backpressure:
  - Stimulus: during drain of {2, 8, 4, 6}, hold out_ready=0 for 3 cycles before the 2nd output.
  - Required: out_data stays 4 with out_valid=1, in_ready=0 throughout, final order 2, 4, 6, 8.
- Boundary values:
  - Stimulus: DW=8, samples 255, 0, 255, 0, ascending.
  - Required: 0, 0, 255, 255.
  - Also, a sample presented with in_valid=0 must not be inserted.
- Reset mid-operation:
  - Stimulus (a): rst for 1 cycle after 2 of 4 samples. Required: no output, k=0, the next frame 3, 1 sorts to 1, 3 with no residue from the old frame.
  - Stimulus (b): rst during drain. Required: out_valid=0 on the next cycle.

Source files
------------

// File: rtl/seq_sorter_n.sv
// Frame sorter: loads up to N unsigned samples into an insertion-sorted cell chain,
// then drains them in ascending or descending order over valid/ready handshakes.
`timescale 1ns/1ps
module seq_sorter_n #(
  parameter int unsigned DW = 8,
  parameter int unsigned N  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          descend,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   c_q [N];
  logic [DW-1:0]   c_d [N];
  logic [CW-1:0]   k_q, k_d;
  logic            dir_q, dir_d;
  logic [N-1:0]    ins;
  logic            cmp_dir;
  logic            accept;
  logic            pop;

  // Strict precedence keeps equal samples in arrival order.
  function automatic logic prec(input logic d, input logic [DW-1:0] a, input logic [DW-1:0] b);
    return d ? (a > b) : (a < b);
  endfunction

  assign out_data = c_q[0];

  // Next-state, handshakes and cell update.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    dir_d     = dir_q;
    c_d       = c_q;
    ins       = '0;
    in_ready  = (state_q == LOAD) && !rst;
    out_valid = (state_q == DRAIN);
    out_last  = (state_q == DRAIN) && (k_q == CW'(1));
    accept    = in_valid && in_ready;
    pop       = out_valid && out_ready;
    cmp_dir   = (k_q == '0) ? descend : dir_q;

    for (int i = 0; i < N; i++) begin
      ins[i] = (CW'(i) >= k_q) || prec(cmp_dir, in_data, c_q[i]);
    end

    if (accept) begin
      if (k_q == '0) dir_d = descend;
      if (ins[0]) c_d[0] = in_data;
      for (int i = 1; i < N; i++) begin
        if (ins[i]) c_d[i] = ins[i-1] ? c_q[i-1] : in_data;
      end
      k_d = k_q + CW'(1);
      if (in_last || (k_q == CW'(N - 1))) state_d = DRAIN;
    end

    if (pop) begin
      for (int i = 0; i < N - 1; i++) begin
        c_d[i] = c_q[i+1];
      end
      c_d[N-1] = '0;
      k_d      = k_q - CW'(1);
      if (k_q == CW'(1)) state_d = LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      k_q     <= '0;
      dir_q   <= 1'b0;
      for (int i = 0; i < N; i++) c_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dir_q   <= dir_d;
      for (int i = 0; i < N; i++) c_q[i] <= c_d[i];
    end
  end

endmodule

// File: tb/tb_seq_sorter_n.sv
// Directed bench for seq_sorter_n (N=4, DW=8): frames with hand-computed sorted outputs.
`timescale 1ns/1ps
module tb_seq_sorter_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       descend;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  int n_checks = 0;
  int n_errors = 0;

  seq_sorter_n #(.DW(8), .N(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .descend(descend),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One input handshake; in_ready is checked before the accepting edge.
  task automatic push(input logic [7:0] d, input logic l, input logic desc);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l; descend = desc;
    check("push_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic expect_out(input logic [7:0] d, input logic l);
    @(negedge clk);
    out_ready = 1'b1;
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_data", 32'(out_data), 32'(d));
    check("out_last", 32'(out_last), 32'(l));
    check("in_ready_drain", 32'(in_ready), 32'd0);
  endtask

  task automatic expect_idle();
    @(negedge clk);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    descend = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    expect_idle();

    // Ascending with in_last on 4th
    push(8'd9, 1'b0, 1'b0); push(8'd3, 1'b0, 1'b0);
    push(8'd7, 1'b0, 1'b0); push(8'd1, 1'b1, 1'b0);
    expect_out(8'd1, 1'b0); expect_out(8'd3, 1'b0);
    expect_out(8'd7, 1'b0); expect_out(8'd9, 1'b1);
    expect_idle();

    // Descending; descend toggled mid-frame must be ignored
    push(8'd5, 1'b0, 1'b1); push(8'd200, 1'b0, 1'b0);
    push(8'd5, 1'b0, 1'b0); push(8'd0, 1'b1, 1'b0);
    expect_out(8'd200, 1'b0); expect_out(8'd5, 1'b0);
    expect_out(8'd5, 1'b0); expect_out(8'd0, 1'b1);
    expect_idle();

    // Short frame
    push(8'd42, 1'b0, 1'b0); push(8'd17, 1'b1, 1'b0);
    expect_out(8'd17, 1'b0); expect_out(8'd42, 1'b1);
    expect_idle();

    // Auto-close at N samples
    push(8'd6, 1'b0, 1'b0); push(8'd2, 1'b0, 1'b0);
    push(8'd9, 1'b0, 1'b0); push(8'd4, 1'b0, 1'b0);
    expect_out(8'd2, 1'b0); expect_out(8'd4, 1'b0);
    expect_out(8'd6, 1'b0); expect_out(8'd9, 1'b1);
    expect_idle();

    // Backpressure before the second output
    push(8'd2, 1'b0, 1'b0); push(8'd8, 1'b0, 1'b0);
    push(8'd4, 1'b0, 1'b0); push(8'd6, 1'b1, 1'b0);
    expect_out(8'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'd4);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    expect_out(8'd4, 1'b0); expect_out(8'd6, 1'b0); expect_out(8'd8, 1'b1);
    expect_idle();

    // Sample with in_valid=0 (and in_last=1) must not be taken
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'd99; in_last = 1'b1;
    @(posedge clk);
    #1 in_last = 1'b0;
    push(8'd255, 1'b0, 1'b0); push(8'd0, 1'b0, 1'b0);
    push(8'd255, 1'b0, 1'b0); push(8'd0, 1'b1, 1'b0);
    expect_out(8'd0, 1'b0); expect_out(8'd0, 1'b0);
    expect_out(8'd255, 1'b0); expect_out(8'd255, 1'b1);
    expect_idle();

    // Reset mid-load discards the partial frame
    push(8'd50, 1'b0, 1'b0); push(8'd60, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rstload_out_valid", 32'(out_valid), 32'd0);
    push(8'd3, 1'b0, 1'b0); push(8'd1, 1'b1, 1'b0);
    expect_out(8'd1, 1'b0); expect_out(8'd3, 1'b1);
    expect_idle();

    // Reset during drain
    push(8'd11, 1'b0, 1'b0); push(8'd33, 1'b0, 1'b0);
    push(8'd22, 1'b0, 1'b0); push(8'd44, 1'b1, 1'b0);
    expect_out(8'd11, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("rstdrain_out_valid", 32'(out_valid), 32'd0);
    check("rstdrain_out_data", 32'(out_data), 32'd0);
    check("rstdrain_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    expect_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
